mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one synchronous-read port of `memory3` between the accelerator-side `cache` (requester A) and the UART `controller` (requester B). It lets both run concurrently on a single BRAM port, which frees the other port. It performs round-robin arbitration with an optional bounded burst lock, so the cache can stream a full image row without interleaving. It also returns per-requester read-valid strobes aligned to the one-cycle BRAM read latency.

## Interface
- `ADDR_WIDTH`, 16, word address width of memory.
- `DATA_WIDTH`, 32, memory word width.
- `MAX_BURST`, 88, maximum consecutive locked grants before a forced yield (88 = one 352-pixel row of 4-pixel words). Must be ≥ 1.

Ports:
- `clk`  in  1  single clock domain; all state is updated on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `a_req`, `b_req`  in  1  access request; held until granted.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_lock`, `b_lock`  in  1  request to retain ownership for the next access.
- `a_addr`, `b_addr`  in  ADDR_WIDTH  word address.
- `a_wdata`, `b_wdata`  in  DATA_WIDTH  write data.
- `a_gnt`, `b_gnt`  out  1  access accepted this cycle (combinational).
- `a_rvalid`, `b_rvalid`  out  1  read data valid this cycle (registered).
- `a_rdata`, `b_rdata`  out  DATA_WIDTH  both driven directly from `mem_do`; qualified only by the matching rvalid.
- `mem_en`, `mem_we`  out  1  memory port enable and write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_di`  out  DATA_WIDTH  memory write data.
- `mem_do`  in  DATA_WIDTH  memory read data, valid one cycle after an enabled read.

## Operation

**State registers**
- `last` (1 bit): last granted requester. Reset value = B, so A wins the first tie.
- `owner_locked` (1 bit).
- `burst_cnt`: width `$clog2(MAX_BURST+1)`.
- `a_rvalid_q`, `b_rvalid_q`.

**Grant selection**, evaluated combinationally each cycle:
- No requests: no grant; `mem_en` = 0.
- Exactly one request: that requester is granted.
- Both requesting, `owner_locked` = 1, and `burst_cnt` < MAX_BURST: the requester in `last` is granted.
- Both requesting, any other case: the requester not in `last` is granted (round-robin).

**Memory drive**
- `mem_en` = `a_gnt | b_gnt`.
- `mem_we`, `mem_addr`, `mem_di` are muxed from the granted requester.
- With no grant, `mem_we` = 0 and addr/data = 0.
- At most one grant per cycle. Never `a_gnt & b_gnt`.

**Register updates on a granted cycle**
- `last` ← granted requester.
- `owner_locked` ← granted requester's `lock` input.
- `burst_cnt`:
  - Set to 1 if the grant switched requester or the previous grant was unlocked.
  - Otherwise incremented, saturating at MAX_BURST.

**Register updates on an idle cycle**
- `owner_locked` ← 0; `burst_cnt` ← 0; `last` unchanged.
- A lock therefore does not survive an idle gap.

**Forced yield and lone requesters**
- When `burst_cnt` = MAX_BURST and the other side is requesting, the other side is granted next, regardless of lock.
- A lone requester is always granted, lock or not. The counter saturates and no bubble is inserted.

**Read return**
- `x_rvalid` ← `x_gnt & ~x_we`, registered.
- `mem_do` is presented unregistered on both rdata outputs.

**Reset** (`rst` = 0, sampled at the clock edge)
- `last` = B, `owner_locked` = 0, `burst_cnt` = 0, both rvalid = 0.
- Grants are forced to 0 while `rst` = 0, so `mem_en` = 0.
- A read granted in the cycle before reset is asserted does not produce an rvalid.

## Timing
- Requesters hold `req`, `we`, `addr`, `wdata`, and `lock` stable until they see `gnt` = 1 at a rising edge. The access occurs in that cycle.
- Grant latency is 0 cycles when uncontended. Worst-case wait with the other side locked is MAX_BURST cycles.
- Read latency: `rvalid` and `rdata` appear exactly 1 cycle after the grant cycle.
- Writes take effect at the end of the grant cycle. A read by either side granted in the next cycle returns the new data.
- Back-to-back grants to the same requester are allowed every cycle: full throughput.
- Combinational paths: req → gnt → `mem_*`. No combinational path exists from `mem_do` to any grant.

## Test plan
1. **Uncontended read.** After reset release, A reads 0x0010, where memory holds 0xDEADBEEF.
   - `a_gnt` = 1 in the same cycle, `mem_en` = 1, `mem_we` = 0.
   - Next cycle: `a_rvalid` = 1, `a_rdata` = 0xDEADBEEF, `b_rvalid` = 0.
2. **Round-robin.** Both sides request continuously, locks = 0.
   - Grants run A, B, A, B, … starting with A.
   - Never simultaneous; `mem_en` = 1 every cycle.
3. **Burst lock.** MAX_BURST = 4, `a_lock` = 1, B requesting throughout.
   - Grants run A, A, A, A, B, A, A, A, A, B.
   - `burst_cnt` reads 1, 2, 3, 4 across each A run.
4. **Write then read.** B writes 0xCAFEF00D to 0x0123; A reads 0x0123 in the next cycle.
   - Write cycle: `mem_we` = 1, `mem_addr` = 0x0123.
   - Cycle after A's grant: `a_rvalid` = 1, `a_rdata` = 0xCAFEF00D.
5. **Reset mid-read.** Assert `rst` = 0 in the cycle after an A read grant.
   - `a_rvalid` = 0 at the next edge and `mem_en` = 0 during reset.
   - After release, with both sides requesting, A is granted first.
6. **Lone locked requester.** A alone with `lock` = 1 for 10 cycles at MAX_BURST = 4.
   - 10 consecutive A grants, `burst_cnt` saturates at 4.
   - B requests on cycle 11 and is granted on cycle 11.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read BRAM port between two requesters,
// with a bounded burst lock and per-requester read-valid strobes.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 88
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  b_req,
  input  logic                  a_we,
  input  logic                  b_we,
  input  logic                  a_lock,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic             last_q, last_d;
  logic             owner_locked_q, owner_locked_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;
  logic             gnt_any;
  logic             hold_owner;

  // Under contention the owner keeps the port only while locked and below the burst cap.
  assign hold_owner = owner_locked_q && (burst_cnt_q < CNT_MAX);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst) begin
      if (a_req && b_req) begin
        if (hold_owner) begin
          a_gnt = (last_q == SEL_A);
          b_gnt = (last_q == SEL_B);
        end else begin
          a_gnt = (last_q == SEL_B);
          b_gnt = (last_q == SEL_A);
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  assign gnt_any = a_gnt | b_gnt;

  always_comb begin
    mem_en   = gnt_any;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (a_gnt) begin
      mem_we   = a_we;
      mem_addr = a_addr;
      mem_di   = a_wdata;
    end else if (b_gnt) begin
      mem_we   = b_we;
      mem_addr = b_addr;
      mem_di   = b_wdata;
    end
  end

  always_comb begin
    last_d         = last_q;
    owner_locked_d = 1'b0;
    burst_cnt_d    = '0;
    if (gnt_any) begin
      last_d         = b_gnt ? SEL_B : SEL_A;
      owner_locked_d = b_gnt ? b_lock : a_lock;
      if ((last_d != last_q) || !owner_locked_q) begin
        burst_cnt_d = CNT_W'(1);
      end else if (burst_cnt_q < CNT_MAX) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d = burst_cnt_q;
      end
    end
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q         <= SEL_B;
      owner_locked_q <= 1'b0;
      burst_cnt_q    <= '0;
      a_rvalid_q     <= 1'b0;
      b_rvalid_q     <= 1'b0;
    end else begin
      last_q         <= last_d;
      owner_locked_q <= owner_locked_d;
      burst_cnt_q    <= burst_cnt_d;
      a_rvalid_q     <= a_rvalid_d;
      b_rvalid_q     <= b_rvalid_d;
    end
  end

  // A read in flight when reset arrives must not surface as a valid strobe.
  assign a_rvalid = a_rvalid_q & rst;
  assign b_rvalid = b_rvalid_q & rst;
  assign a_rdata  = mem_do;
  assign b_rdata  = mem_do;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port BRAM model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req, a_we, b_we, a_lock, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di, mem_do;

  logic [DW-1:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_lock(a_lock), .b_lock(b_lock),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_di;
      else        mem_do <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[16'h0010] = 32'hDEADBEEF;
    idle_inputs();
    rst = 1'b0;
    a_req = 1; b_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_burst_cnt", 32'(dut.burst_cnt_q), 0);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;

    // Uncontended read
    a_req = 1; a_addr = 16'h0010;
    #4;
    chk("t1_a_gnt", 32'(a_gnt), 1);
    chk("t1_b_gnt", 32'(b_gnt), 0);
    chk("t1_mem_en", 32'(mem_en), 1);
    chk("t1_mem_we", 32'(mem_we), 0);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    @(posedge clk); #1;
    a_req = 0;
    chk("t1_a_rvalid", 32'(a_rvalid), 1);
    chk("t1_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("t1_b_rvalid", 32'(b_rvalid), 0);
    @(posedge clk); #1;
    chk("t1_a_rvalid_drop", 32'(a_rvalid), 0);

    // Write then read
    b_req = 1; b_we = 1; b_addr = 16'h0123; b_wdata = 32'hCAFEF00D;
    #4;
    chk("t4_b_gnt", 32'(b_gnt), 1);
    chk("t4_mem_we", 32'(mem_we), 1);
    chk("t4_mem_addr", 32'(mem_addr), 32'h0123);
    chk("t4_mem_di", mem_di, 32'hCAFEF00D);
    @(posedge clk); #1;
    b_req = 0; b_we = 0;
    chk("t4_b_rvalid_wr", 32'(b_rvalid), 0);
    a_req = 1; a_addr = 16'h0123;
    #4;
    chk("t4_a_gnt", 32'(a_gnt), 1);
    @(posedge clk); #1;
    a_req = 0;
    chk("t4_a_rvalid", 32'(a_rvalid), 1);
    chk("t4_a_rdata", a_rdata, 32'hCAFEF00D);

    // Round-robin, no locks
    do_reset();
    a_req = 1; b_req = 1;
    for (int i = 0; i < 6; i++) begin
      #4;
      chk($sformatf("t2_a_gnt_%0d", i), 32'(a_gnt), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t2_b_gnt_%0d", i), 32'(b_gnt), (i % 2 == 0) ? 0 : 1);
      chk($sformatf("t2_mem_en_%0d", i), 32'(mem_en), 1);
      @(posedge clk); #1;
    end

    // Burst lock with forced yield
    do_reset();
    a_req = 1; b_req = 1; a_lock = 1;
    for (int i = 0; i < 10; i++) begin
      automatic bit exp_a = !(i == 4 || i == 9);
      automatic int exp_cnt = !exp_a ? 1 : ((i < 4) ? i + 1 : i - 4);
      #4;
      chk($sformatf("t3_a_gnt_%0d", i), 32'(a_gnt), 32'(exp_a));
      chk($sformatf("t3_b_gnt_%0d", i), 32'(b_gnt), 32'(!exp_a));
      @(posedge clk); #1;
      chk($sformatf("t3_cnt_%0d", i), 32'(dut.burst_cnt_q), 32'(exp_cnt));
    end

    // Lone locked requester saturates, then B gets in immediately
    do_reset();
    a_req = 1; a_lock = 1;
    for (int i = 0; i < 10; i++) begin
      #4;
      chk($sformatf("t6_a_gnt_%0d", i), 32'(a_gnt), 1);
      @(posedge clk); #1;
      chk($sformatf("t6_cnt_%0d", i), 32'(dut.burst_cnt_q), (i < 4) ? i + 1 : 4);
    end
    b_req = 1;
    #4;
    chk("t6_b_gnt", 32'(b_gnt), 1);
    chk("t6_a_gnt", 32'(a_gnt), 0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    // Reset in the cycle after a read grant
    a_req = 1; a_addr = 16'h0010;
    #4;
    chk("t5_a_gnt", 32'(a_gnt), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    a_req = 1; b_req = 1; a_addr = '0;
    #1;
    chk("t5_mem_en_rst", 32'(mem_en), 0);
    chk("t5_a_gnt_rst", 32'(a_gnt), 0);
    chk("t5_a_rvalid_rst", 32'(a_rvalid), 0);
    @(posedge clk); #1;
    chk("t5_a_rvalid_after", 32'(a_rvalid), 0);
    rst = 1'b1;
    #3;
    chk("t5_first_a_gnt", 32'(a_gnt), 1);
    chk("t5_first_b_gnt", 32'(b_gnt), 0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
